dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for a single-port data memory, one IDLE/ACCESS/RESP pass per transaction.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_LIMIT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [2:0]  req0_funct3,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [2:0]  req1_funct3,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        mem_write_en,
    output logic [2:0]  mem_s_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        gnt0, gnt1, hs;
    logic        s_we, s_legal, f3_ok, align_ok;
    logic [2:0]  s_f3;
    logic [31:0] s_addr, s_wdata;
    logic        l_port, l_we, l_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v, rdata_n;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;
    assign gnt0 = req0_valid & (~req1_valid | last_grant);
    assign gnt1 = req1_valid & (~req0_valid | ~last_grant);
`else
    assign gnt0 = req0_valid;
    assign gnt1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = (state == IDLE) & ~rst & gnt0;
    assign req1_ready = (state == IDLE) & ~rst & gnt1;
    assign hs         = req0_ready | req1_ready;

    assign s_we    = req1_ready ? req1_we     : req0_we;
    assign s_f3    = req1_ready ? req1_funct3 : req0_funct3;
    assign s_addr  = req1_ready ? req1_addr   : req0_addr;
    assign s_wdata = req1_ready ? req1_wdata  : req0_wdata;

    // stores allow 000/001/010; loads additionally 100/101
    assign f3_ok    = (s_f3[1:0] != 2'b11) & (s_we ? ~s_f3[2] : ~(s_f3[2] & s_f3[1]));
    assign align_ok = (s_f3[1:0] == 2'b01) ? ~s_addr[0] :
                      (s_f3[1:0] == 2'b10) ? (s_addr[1:0] == 2'b00) : 1'b1;
    assign s_legal  = f3_ok & align_ok & (s_addr < 32'(ADDR_LIMIT));

    // mem_addr/mem_s_type double as the latched address and size of the request
    always_comb begin
        byte_v  = 8'(mem_rdata >> {mem_addr[1:0], 3'b000});
        half_v  = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_v  = mem_s_type[1] ? mem_rdata :
                  mem_s_type[0] ? {{16{half_v[15] & ~mem_s_type[2]}}, half_v} :
                                  {{24{byte_v[7] & ~mem_s_type[2]}}, byte_v};
        rdata_n = (l_we | l_err) ? 32'd0 : load_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            l_port       <= 1'b0;
            l_we         <= 1'b0;
            l_err        <= 1'b0;
            mem_write_en <= 1'b0;
            mem_s_type   <= 3'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            rsp0_valid   <= 1'b0;
            rsp0_rdata   <= 32'd0;
            rsp0_err     <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_rdata   <= 32'd0;
            rsp1_err     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            state        <= (state == IDLE)   ? (hs ? ACCESS : IDLE) :
                            (state == ACCESS) ? RESP : IDLE;
            mem_write_en <= hs & s_we & s_legal;
            rsp0_valid   <= (state == ACCESS) & ~l_port;
            rsp0_err     <= (state == ACCESS) & ~l_port & l_err;
            rsp0_rdata   <= ((state == ACCESS) & ~l_port) ? rdata_n : 32'd0;
            rsp1_valid   <= (state == ACCESS) & l_port;
            rsp1_err     <= (state == ACCESS) & l_port & l_err;
            rsp1_rdata   <= ((state == ACCESS) & l_port) ? rdata_n : 32'd0;
            if (hs) begin
                l_port     <= req1_ready;
                l_we       <= s_we;
                l_err      <= ~s_legal;
                mem_s_type <= s_f3;
                mem_addr   <= s_addr;
                mem_wdata  <= s_wdata;
`ifdef DMEM_ARB_RR_EN
                last_grant <= req1_ready;
`endif
            end
        end
    end
endmodule
